// File: rtl/text_lcd_renderer.sv
// Text-mode LCD renderer: writable text RAM, external registered 8x8 font ROM, inverse video,
// blinking cursor, and RGB/sync outputs aligned at a fixed 3-cycle latency.
module text_lcd_renderer #(
  parameter int unsigned H_OFS        = 216,
  parameter int unsigned V_OFS        = 35,
  parameter int unsigned COLS         = 50,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  localparam int unsigned AW          = $clog2(COLS*ROWS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [10:0]   col,
  input  logic [9:0]    fil,
  input  logic          hd_in,
  input  logic          vd_in,
  input  logic          den_in,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic          cursor_en,
  input  logic [5:0]    cursor_x,
  input  logic [4:0]    cursor_y,
  output logic [12:0]   font_addr,
  input  logic          font_bit,
  output logic          hd_o,
  output logic          vd_o,
  output logic          den_o,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B
);

  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW:0] NCELL_W = (AW+1)'(NCELL);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    wr_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = clear_addr_q;
    ram_wdata    = 8'h20;
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        if (clear_addr_q == AW'(NCELL - 1)) begin
          state_d      = S_IDLE;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        wr_ready  = 1'b1;
        // Out-of-range writes are accepted but dropped; a write alongside clr still lands.
        ram_we    = wr_valid && ({1'b0, wr_addr} < NCELL_W);
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (clr) begin
          state_d      = S_CLEAR;
          clear_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_CLEAR;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  logic [10:0]   x, y, cx, cy;
  logic [2:0]    gc, gr;
  logic          in_win, cur_hit;
  logic [AW-1:0] rd_addr;

  always_comb begin
    x       = col - 11'(H_OFS);
    y       = {1'b0, fil} - 11'(V_OFS);
    cx      = x >> (3 + SCALE_LOG2);
    cy      = y >> (3 + SCALE_LOG2);
    gc      = x[SCALE_LOG2 +: 3];
    gr      = y[SCALE_LOG2 +: 3];
    in_win  = den_in && (32'(cx) < COLS) && (32'(cy) < ROWS);
    cur_hit = (cx == {5'b0, cursor_x}) && (cy == {6'b0, cursor_y});
    rd_addr = in_win ? AW'(32'(cy) * COLS + 32'(cx)) : '0;
  end

  logic [7:0] text_ram [NCELL];
  logic [7:0] char_q;

  // Read-before-write: a same-address collision returns the previous contents.
  always_ff @(posedge CLK) begin
    if (ram_we) text_ram[ram_waddr] <= ram_wdata;
    char_q <= text_ram[rd_addr];
  end

  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d, vd_prev_q;

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (vd_prev_q && !vd_in) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  logic [2:0]  gr1_q, gc1_q;
  logic        win1_q, cur1_q, win2_q, cur2_q, inv2_q;
  logic [2:0]  hd_p_q, vd_p_q, den_p_q;
  logic [23:0] rgb_q, rgb_d;

  assign font_addr = {char_q[6:0], gr1_q, gc1_q};

  always_comb begin
    rgb_d = '0;
    if (win2_q) rgb_d = (font_bit ^ inv2_q ^ cur2_q) ? FG_RGB : BG_RGB;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vd_prev_q <= 1'b1;
      frame_q   <= '0;
      blink_q   <= 1'b1;
      gr1_q     <= '0;
      gc1_q     <= '0;
      win1_q    <= 1'b0;
      cur1_q    <= 1'b0;
      win2_q    <= 1'b0;
      cur2_q    <= 1'b0;
      inv2_q    <= 1'b0;
      hd_p_q    <= '1;
      vd_p_q    <= '1;
      den_p_q   <= '0;
      rgb_q     <= '0;
    end else begin
      vd_prev_q <= vd_in;
      frame_q   <= frame_d;
      blink_q   <= blink_d;
      gr1_q     <= gr;
      gc1_q     <= gc;
      win1_q    <= in_win;
      cur1_q    <= cursor_en && cur_hit && blink_q;
      win2_q    <= win1_q;
      cur2_q    <= cur1_q;
      inv2_q    <= char_q[7];
      hd_p_q    <= {hd_p_q[1:0], hd_in};
      vd_p_q    <= {vd_p_q[1:0], vd_in};
      den_p_q   <= {den_p_q[1:0], den_in};
      rgb_q     <= rgb_d;
    end
  end

  assign hd_o  = hd_p_q[2];
  assign vd_o  = vd_p_q[2];
  assign den_o = den_p_q[2];
  assign R     = rgb_q[23:16];
  assign G     = rgb_q[15:8];
  assign B     = rgb_q[7:0];

endmodule

// File: tb/tb_text_lcd_renderer.sv
// Scoreboard bench for text_lcd_renderer: shadow text RAM, blink model and font ROM model.
module tb_text_lcd_renderer;
  localparam int unsigned H = 216, V = 35, NC = 50, NR = 30, NCELL = 1500, BF = 30;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h203040;

  logic        CLK = 1'b0, RST = 1'b1;
  logic [10:0] col = '0;
  logic [9:0]  fil = '0;
  logic        hd_in = 1'b1, vd_in = 1'b1, den_in = 1'b0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [10:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        clr = 1'b0, cursor_en = 1'b0;
  logic [5:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic [12:0] font_addr;
  logic        font_bit = 1'b0;
  logic        hd_o, vd_o, den_o;
  logic [7:0]  R, G, B;

  always #5 CLK = ~CLK;

  text_lcd_renderer #(.BG_RGB(BG)) dut (
    .CLK(CLK), .RST(RST), .col(col), .fil(fil), .hd_in(hd_in), .vd_in(vd_in), .den_in(den_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y), .font_addr(font_addr),
    .font_bit(font_bit), .hd_o(hd_o), .vd_o(vd_o), .den_o(den_o), .R(R), .G(G), .B(B)
  );

  logic [7:0]  shadow [NCELL];
  logic [26:0] exp_q[$];
  logic [13:0] fa_q[$];
  int checks = 0, errors = 0, font_mode = 0, bcnt = 0;
  logic bphase = 1'b1, vdprev = 1'b1;

  function automatic logic rom(input logic [12:0] a);
    case (font_mode)
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ^(a ^ {a[7:0], a[12:8]} ^ 13'h0B5);
    endcase
  endfunction

  always @(posedge CLK) font_bit <= rom(font_addr);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    bcnt = 0; bphase = 1'b1; vdprev = 1'b1;
    exp_q.delete(); fa_q.delete();
  endtask

  task automatic fill_shadow();
    for (int i = 0; i < int'(NCELL); i++) shadow[i] = 8'h20;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 3000) begin step(); n++; end
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a[10:0]; wr_data = d;
    step();
    wr_valid = 1'b0;
    if (a < int'(NCELL)) shadow[a] = d;
  endtask

  // Drive one pixel and queue what should emerge: font address next cycle, RGB/syncs 3 cycles on.
  task automatic drive_pix(input int c, input int f, input logic d, input logic h, input logic v);
    logic [10:0] x, y, cx, cy;
    logic [2:0]  gc, gr;
    logic        win, cur, on;
    logic [7:0]  ch;
    logic [12:0] fa;
    logic [23:0] rgb;
    col = c[10:0]; fil = f[9:0]; den_in = d; hd_in = h; vd_in = v;
    x  = col - 11'(H);
    y  = {1'b0, fil} - 11'(V);
    cx = x >> 4; cy = y >> 4; gc = x[3:1]; gr = y[3:1];
    win = d && (32'(cx) < NC) && (32'(cy) < NR);
    ch = 8'h00;
    if (win) ch = shadow[int'(cy) * int'(NC) + int'(cx)];
    fa  = {ch[6:0], gr, gc};
    cur = cursor_en && (cx == 11'(cursor_x)) && (cy == 11'(cursor_y)) && bphase;
    on  = rom(fa) ^ ch[7] ^ cur;
    rgb = !win ? 24'h0 : (on ? FG : BG);
    exp_q.push_back({rgb, h, v, d});
    fa_q.push_back({win, fa});
    if (vdprev && !v) begin
      if (bcnt == int'(BF) - 1) begin bcnt = 0; bphase = ~bphase; end
      else bcnt++;
    end
    vdprev = v;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wr_ready); end
    checks++;
    if ({R, G, B, hd_o, vd_o, den_o} !== {24'h0, 3'b110}) begin
      errors++; $display("FAIL reset_out got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, {24'h0, 3'b110});
    end
  endtask

  task automatic test_clear();
    int n;
    logic [26:0] e;
    logic [13:0] fa;
    wr_valid = 1'b1; wr_addr = 11'd7; wr_data = 8'h99;
    RST = 1'b0;
    model_reset();
    wait_ready(n);
    wr_valid = 1'b0;
    checks++;
    if (n != 1500) begin errors++; $display("FAIL clear_cycles got %0d exp 1500", n); end
    fill_shadow();
    font_mode = 0;
    for (int i = 0; i < int'(NCELL) + 2; i++) begin
      if (i < int'(NCELL))
        drive_pix(H + (i % 50) * 16 + 2 * (i % 8), V + (i / 50) * 16 + 2 * ((i / 8) % 8), 1'b1, (i % 7) != 0, 1'b1);
      step();
      if (i < int'(NCELL)) begin
        fa = fa_q.pop_front();
        if (fa[13]) begin
          checks++;
          if (font_addr !== fa[12:0]) begin errors++; $display("FAIL clear_fa got %h exp %h", font_addr, fa[12:0]); end
        end
      end
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL clear_pix got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
  endtask

  task automatic test_write_render();
    logic [26:0] e;
    do_write(51, 8'h41);
    font_mode = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_pix(H + 24, V + 16, 1'b1, 1'b0, 1'b0);
      if (i == 1) drive_pix(H + 24, V + 16, 1'b0, 1'b1, 1'b1);
      step();
      if (i == 0) begin
        void'(fa_q.pop_front()); checks++;
        if (font_addr !== 13'h1044) begin errors++; $display("FAIL write_fa got %h exp 1044", font_addr); end
      end
      if (i == 1) void'(fa_q.pop_front());
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL write_pix got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
  endtask

  task automatic test_inverse();
    logic [26:0] e;
    for (int m = 0; m < 2; m++) begin
      font_mode = (m == 0) ? 1 : 2;
      for (int i = 0; i < 4; i++) begin
        wr_valid = (m == 0 && i == 0);
        wr_addr = 11'd51; wr_data = 8'hC1;
        if (i < 2) drive_pix(H + 28, V + 18, 1'b1, 1'b1, 1'b1);
        if (wr_valid) shadow[51] = 8'hC1;
        step();
        if (i < 2) void'(fa_q.pop_front());
        if (i >= 2) begin
          e = exp_q.pop_front(); checks++;
          if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
            errors++; $display("FAIL inverse_pix got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, e);
          end
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_cursor_blink();
    logic [26:0] e;
    int n;
    n = 65 * 3;
    cursor_en = 1'b1; cursor_x = 6'd3; cursor_y = 5'd1; font_mode = 1;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        case (i % 3)
          0:       drive_pix(H + 50, V + 22, 1'b1, 1'b1, 1'b1);
          1:       drive_pix(0, 0, 1'b0, 1'b1, 1'b0);
          default: drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
        endcase
      end
      step();
      if (i < n) void'(fa_q.pop_front());
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL cursor_pix n=%0d got %h exp %h", i, {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [26:0] e;
    logic [13:0] fa;
    int pc[8] = '{215, H, H + 799, H + 800, 300, 300, H + 787, H + 24};
    int pf[8] = '{V + 16, V, V + 479, V + 100, V + 480, V + 100, V + 5, V + 16};
    logic pd[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL bound_ready got %b exp 1", wr_ready); end
    do_write(1500, 8'h7E);
    font_mode = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive_pix(pc[i], pf[i], pd[i], 1'b1, 1'b1);
      step();
      if (i < 8) begin
        fa = fa_q.pop_front();
        if (fa[13]) begin
          checks++;
          if (font_addr !== fa[12:0]) begin errors++; $display("FAIL bound_fa got %h exp %h", font_addr, fa[12:0]); end
        end
      end
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL bound_pix i=%0d got %h exp %h", i - 2, {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
  endtask

  task automatic test_clr_reset();
    int n;
    logic [26:0] e;
    wr_valid = 1'b1; wr_addr = 11'd60; wr_data = 8'hC5; clr = 1'b1;
    step();
    wr_valid = 1'b0; clr = 1'b0;
    wait_ready(n);
    checks++;
    if (n != 1500) begin errors++; $display("FAIL clr_cycles got %0d exp 1500", n); end
    fill_shadow();
    font_mode = 2;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_pix(H + 164, V + 19, 1'b1, 1'b1, 1'b1);
      if (i == 1) drive_pix(H + 24, V + 16, 1'b1, 1'b1, 1'b1);
      step();
      if (i < 2) void'(fa_q.pop_front());
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL clr_pix got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin drive_pix(H + 24, V + 16, 1'b1, 1'b0, 1'b1); step(); end
    checks++;
    if (den_o !== 1'b1) begin errors++; $display("FAIL prerst_den got %b exp 1", den_o); end
    RST = 1'b1;
    #1;
    checks++;
    if ({R, G, B, hd_o, vd_o, den_o, wr_ready} !== {24'h0, 4'b1100}) begin
      errors++; $display("FAIL midrst_out got %h exp %h", {R, G, B, hd_o, vd_o, den_o, wr_ready}, {24'h0, 4'b1100});
    end
    step();
    RST = 1'b0;
    model_reset();
    wait_ready(n);
    checks++;
    if (n != 1500) begin errors++; $display("FAIL rst_clear_cycles got %0d exp 1500", n); end
    fill_shadow();
  endtask

  task automatic test_back_to_back();
    logic [26:0] e;
    logic [13:0] fa;
    int wa, n;
    n = 400;
    for (int i = 0; i < 30; i++) do_write(int'($urandom_range(1499, 0)), 8'($urandom));
    cursor_en = 1'b1; cursor_x = 6'($urandom_range(49, 0)); cursor_y = 5'($urandom_range(29, 0));
    font_mode = 0;
    for (int i = 0; i < n + 2; i++) begin
      wr_valid = 1'b0;
      if (i < n) begin
        wa = int'($urandom_range(1599, 0));
        if ($urandom_range(3, 0) == 0) begin wr_valid = 1'b1; wr_addr = wa[10:0]; wr_data = 8'($urandom); end
        drive_pix(H - 8 + int'($urandom_range(819, 0)), V - 4 + int'($urandom_range(489, 0)),
                  $urandom_range(7, 0) != 0, 1'($urandom), $urandom_range(15, 0) != 0);
        if (wr_valid && wa < int'(NCELL)) shadow[wa] = wr_data;
      end
      step();
      if (i < n) begin
        fa = fa_q.pop_front();
        if (fa[13]) begin
          checks++;
          if (font_addr !== fa[12:0]) begin errors++; $display("FAIL b2b_fa got %h exp %h", font_addr, fa[12:0]); end
        end
      end
      if (i >= 2) begin
        e = exp_q.pop_front(); checks++;
        if ({R, G, B, hd_o, vd_o, den_o} !== e) begin
          errors++; $display("FAIL b2b_pix got %h exp %h", {R, G, B, hd_o, vd_o, den_o}, e);
        end
      end
    end
    wr_valid = 1'b0; cursor_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_render();
    test_inverse();
    test_cursor_blink();
    test_boundaries();
    test_clr_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
